// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply / restoring divide unit producing HI/LO
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-low reset
//   start     operation request, accepted only when idle
//   op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   a, b      multiplicand/dividend, multiplier/divisor (sampled with start)
//   busy      operation in flight
//   done      one-cycle pulse, hi/lo valid
//   div_zero  one-cycle pulse with done for a zero divisor
//   hi, lo    product[2W-1:W]/product[W-1:0], or remainder/quotient
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = 2 * WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DZERO
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CW-1:0]        r_count;
    logic [AW-1:0]        r_acc;
    logic [WIDTH-1:0]     r_mcand;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_is_div;
    logic                 r_done;
    logic                 r_div_zero;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    // Operands are signed only for MULT/DIV (op[0]==0).
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_last;

    assign w_a_neg = ~op[0] & a[WIDTH-1];
    assign w_b_neg = ~op[0] & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;
    assign w_last  = (r_count == CW'(WIDTH - 1));

    // Multiply step: the multiplier sits in the low half and is consumed LSB first
    // while the partial product grows in the high half and shifts right.
    logic [WIDTH:0]       w_mul_sum;
    logic [AW-1:0]        w_mul_step;

    assign w_mul_sum  = r_acc[AW-1:WIDTH] + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_mul_step = {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide step: shift {remainder, dividend} left, try subtracting the divisor
    // from the W+1-bit partial remainder, keep the difference if it did not go negative.
    logic [AW-1:0]        w_shift;
    logic                 w_div_ge;
    logic [WIDTH:0]       w_div_diff;
    logic [AW-1:0]        w_div_step;

    assign w_shift    = {r_acc[AW-2:0], 1'b0};
    assign w_div_ge   = (w_shift[AW-1:WIDTH] >= {1'b0, r_mcand});
    assign w_div_diff = w_shift[AW-1:WIDTH] - {1'b0, r_mcand};
    assign w_div_step = w_div_ge ? {w_div_diff, w_shift[WIDTH-1:1], 1'b1}
                                 : {w_shift[AW-1:1], 1'b0};

    // Sign correction applied in FIX.
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    assign w_prod = r_neg_q ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0]   : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (!op[1]) begin
                        w_next = S_MUL;
                    end else if (b == '0) begin
                        w_next = S_DZERO;
                    end else begin
                        w_next = S_DIV;
                    end
                end
            end
            S_MUL:   w_next = w_last ? S_FIX : S_MUL;
            S_DIV:   w_next = w_last ? S_FIX : S_DIV;
            S_FIX:   w_next = S_IDLE;
            S_DZERO: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_is_div   <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_count  <= '0;
                        r_acc    <= {{(WIDTH + 1){1'b0}}, w_a_mag};
                        r_mcand  <= w_b_mag;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_is_div <= op[1];
                    end
                end
                S_MUL: begin
                    r_acc   <= w_mul_step;
                    r_count <= r_count + CW'(1);
                end
                S_DIV: begin
                    r_acc   <= w_div_step;
                    r_count <= r_count + CW'(1);
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done <= 1'b1;
                end
                S_DZERO: begin
                    r_done     <= 1'b1;
                    r_div_zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit at WIDTH=32 and WIDTH=8
module tb_muldiv_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start, start8;
    logic [1:0]  op, op8;
    logic [31:0] a, b;
    logic [7:0]  a8, b8;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;
    logic        busy8, done8, div_zero8;
    logic [7:0]  hi8, lo8;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitors: pop the oldest expectation whenever a DUT signals done.
    always @(negedge clk) begin : mon32
        exp_t e;
        if (reset && done) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w32_unexpected_done actual=1 expected=0");
            end else begin
                e = q32.pop_front();
                check("w32_hi", 64'(hi), 64'(e.hi));
                check("w32_lo", 64'(lo), 64'(e.lo));
                check("w32_div_zero", 64'(div_zero), 64'(e.dz));
                check("w32_busy_at_done", 64'(busy), 64'd0);
            end
        end
        if (reset && div_zero && !done) begin
            checks++;
            errors++;
            $display("FAIL w32_div_zero_without_done actual=1 expected=0");
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (reset && done8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w8_unexpected_done actual=1 expected=0");
            end else begin
                e = q8.pop_front();
                check("w8_hi", 64'(hi8), 64'(e.hi[7:0]));
                check("w8_lo", 64'(lo8), 64'(e.lo[7:0]));
                check("w8_div_zero", 64'(div_zero8), 64'(e.dz));
                check("w8_busy_at_done", 64'(busy8), 64'd0);
            end
        end
    end

    // Issue one op from a negedge with the DUT idle; returns at the negedge of the done cycle.
    // lat = edges after the start edge until done; glitch >= 0 pulses start with other operands mid-flight.
    task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz,
                         input int lat, input int glitch);
        exp_t e;
        int   n;
        int   busy_cnt;
        e.hi = eh; e.lo = el; e.dz = edz;
        q32.push_back(e);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        busy_cnt = 0;
        while (n < lat + 10) begin
            @(negedge clk);
            if (done) break;
            if (busy) busy_cnt++;
            if (n == glitch) begin
                start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
            end else begin
                start = 1'b0;
            end
            n++;
        end
        start = 1'b0;
        check("w32_latency", 64'(n), 64'(lat));
        check("w32_busy_cycles", 64'(busy_cnt), 64'(lat));
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] eh, input logic [7:0] el, input logic edz,
                        input int lat);
        exp_t e;
        int   n;
        e.hi = 32'(eh); e.lo = 32'(el); e.dz = edz;
        q8.push_back(e);
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        n = 0;
        while (n < lat + 10) begin
            @(negedge clk);
            if (done8) break;
            n++;
        end
        check("w8_latency", 64'(n), 64'(lat));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin : stim
        int dcnt;
        reset = 1'b0; start = 1'b0; start8 = 1'b0;
        op = 2'b00; a = '0; b = '0; op8 = 2'b00; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs32", {29'd0, busy, done, div_zero, hi, lo}, 64'd0);
        check("reset_outputs8", {45'd0, busy8, done8, div_zero8, hi8, lo8}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        run32(2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, -1);
        run32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, -1);
        run32(2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 33, -1);
        run32(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, -1);
        run32(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, -1);
        run32(2'b11, 32'd100,      32'd0,        32'h00000000, 32'h80000000, 1'b1, 1,  -1);
        run32(2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33, -1);
        run32(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, -1);
        run32(2'b01, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0, 33, -1);
        run32(2'b11, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0, 33, -1);
        run32(2'b00, 32'd5,        32'd6,        32'h00000000, 32'h0000001E, 1'b0, 33, 3);

        run8(2'b00, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0, 9);
        run8(2'b10, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 9);
        run8(2'b10, 8'h80, 8'h00, 8'h00, 8'h80, 1'b1, 1);
        run8(2'b11, 8'hF0, 8'h0D, 8'h06, 8'h12, 1'b0, 9);

        // Reset in the middle of a MULT: no done, outputs cleared.
        @(negedge clk);
        op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_hi", 64'(hi), 64'd0);
        check("midreset_lo", 64'(lo), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        reset = 1'b1;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("midreset_no_done", 64'(dcnt), 64'd0);

        run32(2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, -1);

        repeat (3) @(negedge clk);
        check("q32_drained", 64'(q32.size()), 64'd0);
        check("q8_drained", 64'(q8.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
